// File: rtl/ps2_key_capture.sv
// PS/2 keyboard receiver with a make/break tracker.
// It deserialises and checks device frames, then holds the last pressed key and a press count.
module ps2_key_capture #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_vld,
   output logic       frame_err,
   output logic [7:0] code,
   output logic       key_down,
   output logic [7:0] press_cnt
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0] BRK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE = 8'hE0;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [1:0]      r_clk_sync;
   logic [1:0]      r_dat_sync;
   logic            r_clk_prev;
   logic [7:0]      r_sreg;
   logic [2:0]      r_bit_cnt;
   logic            r_par_ok;
   logic [TW-1:0]   r_tcnt;
   logic            r_brk;
   logic            w_clk_s;
   logic            w_dat;
   logic            w_fall;
   logic            w_tmo;
   logic            w_frame_ok;
   logic            w_frame_bad;

   // Both lines are idle-high, so the synchronisers reset to 1 to avoid a false edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[0], ps2_clk};
         r_dat_sync <= {r_dat_sync[0], ps2_data};
         r_clk_prev <= r_clk_sync[1];
      end
   end

   assign w_clk_s = r_clk_sync[1];
   assign w_dat   = r_dat_sync[1];
   assign w_fall  = r_clk_prev & ~w_clk_s;
   // A falling edge in the same cycle wins over the timeout, so the two strobes never collide.
   assign w_tmo   = (r_state != S_IDLE) && !w_fall && (r_tcnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_fall && !w_dat)              w_next = S_DATA;
         S_DATA:   if (w_fall && r_bit_cnt == 3'd7)   w_next = S_PARITY;
         S_PARITY: if (w_fall)                        w_next = S_STOP;
         S_STOP:   if (w_fall)                        w_next = S_IDLE;
         default:                                     w_next = S_IDLE;
      endcase
      if (w_tmo) w_next = S_IDLE;
   end

   always_comb begin
      w_frame_ok  = 1'b0;
      w_frame_bad = w_tmo;
      if (r_state == S_STOP && w_fall) begin
         if (w_dat && r_par_ok) w_frame_ok  = 1'b1;
         else                   w_frame_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sreg    <= '0;
         r_bit_cnt <= '0;
         r_par_ok  <= 1'b0;
         r_tcnt    <= '0;
      end else begin
         if (r_state == S_IDLE || w_fall || w_tmo) r_tcnt <= '0;
         else                                      r_tcnt <= r_tcnt + 1'b1;
         if (w_fall) begin
            case (r_state)
               S_IDLE:   r_bit_cnt <= '0;
               S_DATA: begin
                  r_sreg[r_bit_cnt] <= w_dat;
                  r_bit_cnt         <= r_bit_cnt + 1'b1;
               end
               S_PARITY: r_par_ok <= (^r_sreg) ^ w_dat;
               default:  ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_byte   <= '0;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         byte_vld  <= w_frame_ok;
         frame_err <= w_frame_bad;
         if (w_frame_ok) rx_byte <= r_sreg;
      end
   end

   // Typematic repeats of the held key do not bump the press count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_brk     <= 1'b0;
         code      <= '0;
         key_down  <= 1'b0;
         press_cnt <= '0;
      end else if (byte_vld) begin
         if (rx_byte == BRK_CODE) begin
            r_brk <= 1'b1;
         end else if (rx_byte == EXT_CODE) begin
            r_brk <= r_brk;
         end else if (r_brk) begin
            r_brk <= 1'b0;
            if (rx_byte == code) key_down <= 1'b0;
         end else begin
            if (!key_down || rx_byte != code) press_cnt <= press_cnt + 1'b1;
            code     <= rx_byte;
            key_down <= 1'b1;
         end
      end
   end

endmodule
